// File: rtl/ifid_reg.sv
// IF/ID pipeline register with hold/flush/bubble insertion and the branch-shadow chain for fetch.
// Optional performance counters are enabled by defining IFID_PERF_CNT_EN.
module ifid_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        valid_out,
  output logic        halted,
  output logic        ab,
  output logic        ab_idex,
  output logic        ab_exmem,
  output logic        ab_memwb
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  // Jumps (001xx) and conditional branches (011xx) redirect fetch.
  function automatic logic is_ctrl(input logic [4:0] op);
    logic r;
    case (op[4:2])
      3'b001:  r = 1'b1;
      3'b011:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        ab_idex_q, ab_idex_d;
  logic        ab_exmem_q, ab_exmem_d;
  logic        ab_memwb_q, ab_memwb_d;
  logic        ab_s;

  assign ab_s = valid_q & is_ctrl(instr_q[15:11]);

  // ID register, halt latch and shadow chain next-state
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    ab_idex_d  = 1'b0;
    ab_exmem_d = 1'b0;
    ab_memwb_d = 1'b0;
    if (rst) begin
      instr_d  = NOP_INSTR;
      pc_d     = 16'd0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else begin
      ab_idex_d  = ab_s & ~stall & ~flush;
      ab_exmem_d = ab_idex_q;
      ab_memwb_d = ab_exmem_q;
      if (flush) begin
        instr_d = NOP_INSTR;
        pc_d    = 16'd0;
        valid_d = 1'b0;
      end else if (halted_q) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else if (stall) begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
      end else begin
        instr_d = instr_in;
        pc_d    = pc_in;
        valid_d = (instr_in != NOP_INSTR);
        if (instr_in[15:11] == 5'b00000) begin
          halted_d = 1'b1;
        end else begin
          halted_d = halted_q;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    instr_q    <= instr_d;
    pc_q       <= pc_d;
    valid_q    <= valid_d;
    halted_q   <= halted_d;
    ab_idex_q  <= ab_idex_d;
    ab_exmem_q <= ab_exmem_d;
    ab_memwb_q <= ab_memwb_d;
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;
  assign halted    = halted_q;
  assign ab        = ab_s;
  assign ab_idex   = ab_idex_q;
  assign ab_exmem  = ab_exmem_q;
  assign ab_memwb  = ab_memwb_q;

`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating stall and bubble counters
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (rst) begin
      stall_cnt_d  = 16'd0;
      bubble_cnt_d = 16'd0;
    end else begin
      if (stall & ~flush) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (!valid_q) begin
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    stall_cnt_q  <= stall_cnt_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_reg.sv
// Scoreboard bench for ifid_reg: a stimulus process pushes expected state, a monitor pops and compares.
module tb_ifid_reg;
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr_in = 16'h0800;
  logic [15:0] pc_in = 16'h0000;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instr_out, pc_out;
  logic        valid_out, halted, ab, ab_idex, ab_exmem, ab_memwb;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_cnt, bubble_cnt;
`endif

  ifid_reg #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
    .stall(stall), .flush(flush), .instr_out(instr_out), .pc_out(pc_out),
    .valid_out(valid_out), .halted(halted), .ab(ab), .ab_idex(ab_idex),
    .ab_exmem(ab_exmem), .ab_memwb(ab_memwb)
`ifdef IFID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        halted;
    logic        ab;
    logic        idex;
    logic        exmem;
    logic        memwb;
    logic [15:0] scnt;
    logic [15:0] bcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: ID contents plus history of branches leaving ID
  logic [15:0] m_instr = NOP;
  logic [15:0] m_pc = 16'h0000;
  logic        m_valid = 1'b0;
  logic        m_halted = 1'b0;
  logic        hist[3] = '{1'b0, 1'b0, 1'b0};
  int          m_scnt = 0;
  int          m_bcnt = 0;

  function automatic logic ctrl_op(input logic [15:0] ins);
    int grp;
    grp = int'(ins >> 11) / 4;
    return (grp == 1) || (grp == 3);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f,
                      input logic [15:0] ins, input logic [15:0] pc);
    exp_t e;
    logic ab_now;
    @(negedge clk);
    rst = r; stall = s; flush = f; instr_in = ins; pc_in = pc;
    ab_now = m_valid && ctrl_op(m_instr);
    if (r) begin
      m_instr = NOP; m_pc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
      hist = '{1'b0, 1'b0, 1'b0};
      m_scnt = 0; m_bcnt = 0;
    end else begin
      if (s && !f && m_scnt < 65535) m_scnt++;
      if (!m_valid && m_bcnt < 65535) m_bcnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = ab_now && !s && !f;
      if (f) begin
        m_instr = NOP; m_pc = 16'h0000; m_valid = 1'b0;
      end else if (m_halted) begin
        m_instr = NOP; m_valid = 1'b0;
      end else if (!s) begin
        m_instr = ins; m_pc = pc; m_valid = (ins != NOP);
        if ((ins >> 11) == 16'd0) m_halted = 1'b1;
      end
    end
    e.instr = m_instr; e.pc = m_pc; e.valid = m_valid; e.halted = m_halted;
    e.ab = m_valid && ctrl_op(m_instr);
    e.idex = hist[0]; e.exmem = hist[1]; e.memwb = hist[2];
    e.scnt = 16'(m_scnt); e.bcnt = 16'(m_bcnt);
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs after every edge that has an expectation queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instr_out", instr_out, e.instr);
        chk("pc_out", pc_out, e.pc);
        chk("valid_out", {15'd0, valid_out}, {15'd0, e.valid});
        chk("halted", {15'd0, halted}, {15'd0, e.halted});
        chk("ab", {15'd0, ab}, {15'd0, e.ab});
        chk("ab_idex", {15'd0, ab_idex}, {15'd0, e.idex});
        chk("ab_exmem", {15'd0, ab_exmem}, {15'd0, e.exmem});
        chk("ab_memwb", {15'd0, ab_memwb}, {15'd0, e.memwb});
`ifdef IFID_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, e.scnt);
        chk("bubble_cnt", bubble_cnt, e.bcnt);
`endif
      end
    end
  end

  initial begin
    logic [15:0] ins;
    int sel;
    // Directed sequences from the test plan
    step(1'b1, 1'b0, 1'b0, NOP, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'hC123, 16'h0002);
    step(1'b0, 1'b0, 1'b0, 16'h6004, 16'h0004);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, NOP, 16'h0006);
    step(1'b0, 1'b0, 1'b0, 16'h6004, 16'h0008);
    step(1'b0, 1'b1, 1'b0, 16'hC000, 16'h000A);
    step(1'b0, 1'b1, 1'b0, 16'hC000, 16'h000A);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, NOP, 16'h000A);
    step(1'b0, 1'b1, 1'b1, 16'hA000, 16'h000C);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h000E);
    step(1'b0, 1'b0, 1'b0, 16'hC001, 16'h0010);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'hC002, 16'h0012);
    step(1'b0, 1'b0, 1'b1, 16'hC003, 16'h0014);
    step(1'b1, 1'b0, 1'b0, 16'hC004, 16'h0016);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 19));
      ins = 16'($urandom);
      if (sel < 3) ins = NOP;
      else if (sel < 7) ins = {($urandom_range(0, 1) == 0) ? 3'b001 : 3'b011, ins[12:0]};
      else if (sel == 7 && $urandom_range(0, 4) == 0) ins = 16'h0000 | {5'b00000, ins[10:0]};
      else if (ins[15:11] == 5'b00000) ins[15] = 1'b1;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, ins, 16'($urandom));
    end
`ifdef IFID_PERF_CNT_EN
    step(1'b1, 1'b0, 1'b0, NOP, 16'h0000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'hC100, 16'h0002);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'hC100, 16'h0002);
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 1'b0, 16'hC100, 16'h0002);
`endif
    @(posedge clk);
    #2;
    chk("drain", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
